// File: rtl/prbs_stream_gen.sv
// PRBS-31 (x^31+x^28+1) AXI-Stream pattern source with burst/continuous runs, seed load and error injection.
// Latency: enable rising in IDLE -> first word valid one clk edge later; then one word per clk when ready is high.
// Backpressure: TDATA/TVALID held stable while TREADY is low; TVALID never retracted except by reset.
//
// Ports:
//   clk, aresetn        : clock and synchronous active-low reset
//   M_AXIS_TDATA/TVALID : PRBS word output, M_AXIS_TREADY downstream ready
//   enable              : level, start or keep generating
//   load_seed, seed     : load LFSR in IDLE (seed 0 maps to all ones)
//   burst_len           : words per run, 0 = continuous; latched at run start
//   inject_err          : invert TDATA[0] of the next word loaded into the output register
//   word_count          : handshakes since the last run start
//   busy, done          : state == RUN, state == DONE
module prbs_stream_gen #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   aresetn,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  input  logic                   enable,
  input  logic                   load_seed,
  input  logic [30:0]            seed,
  input  logic [31:0]            burst_len,
  input  logic                   inject_err,
  output logic [31:0]            word_count,
  output logic                   busy,
  output logic                   done
);

  localparam logic [30:0] LFSR_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [30:0]            lfsr;
  logic [30:0]            lfsr_src;
  logic [30:0]            lfsr_adv;
  logic [30:0]            walk_s;
  logic [30:0]            seed_eff;
  logic [TDATA_WIDTH-1:0] word_nxt;
  logic [TDATA_WIDTH-1:0] inj_mask;
  logic [31:0]            burst_q;
  logic                   inj_pend;
  logic                   hs;
  logic                   last_word;
  logic                   seed_ok;
  logic                   run_start;
  logic                   load_word;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by all ones.
  assign seed_eff  = (seed == 31'd0) ? LFSR_ONES : seed;
  assign seed_ok   = (state == IDLE) && load_seed;
  assign run_start = (state == IDLE) && enable;
  // A seed loaded in the same cycle as the run start must feed the first word.
  assign lfsr_src  = seed_ok ? seed_eff : lfsr;
  assign hs        = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_word = (burst_q != 32'd0) && ((word_count + 32'd1) == burst_q);

  // Unrolled word generation: TDATA_WIDTH LFSR steps per clock, first bit to the MSB.
  always_comb begin
    walk_s   = lfsr_src;
    word_nxt = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      word_nxt[TDATA_WIDTH-1-i] = walk_s[30] ^ walk_s[27];
      walk_s = {walk_s[29:0], walk_s[30] ^ walk_s[27]};
    end
    lfsr_adv = walk_s;
  end

  // A pulse arriving on the load cycle itself applies to the word being loaded.
  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = inj_pend | inject_err;
  end

  // Next-state and word-load decision.
  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          load_word = 1'b1;
        end
      end
      RUN: begin
        if (hs) begin
          if (last_word) begin
            state_nxt = DONE;
          end else if (!enable) begin
            state_nxt = IDLE;
          end else begin
            load_word = 1'b1;
          end
        end
      end
      DONE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      lfsr          <= LFSR_ONES;
      inj_pend      <= 1'b0;
      word_count    <= 32'd0;
      burst_q       <= 32'd0;
    end else begin
      if (load_word) begin
        // The LFSR advances on the clean word; injection only touches the output copy.
        M_AXIS_TDATA  <= word_nxt ^ inj_mask;
        M_AXIS_TVALID <= 1'b1;
        lfsr          <= lfsr_adv;
        inj_pend      <= 1'b0;
      end else begin
        if (seed_ok) begin
          lfsr <= seed_eff;
        end
        if (inject_err) begin
          inj_pend <= 1'b1;
        end
        // Handshake without a follow-on word: run is ending (burst end or enable low).
        if (state == RUN && hs) begin
          M_AXIS_TVALID <= 1'b0;
        end
      end

      if (run_start) begin
        word_count <= 32'd0;
        burst_q    <= burst_len;
      end else if (state == RUN && hs) begin
        word_count <= word_count + 32'd1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Self-checking bench for prbs_stream_gen against a bit-history PRBS-31 model.
// Latency: n/a (testbench).
// Backpressure: drives random and directed TREADY patterns.
module tb_prbs_stream_gen;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          tready;
  logic          enable;
  logic          load_seed;
  logic [30:0]   seed;
  logic [31:0]   burst_len;
  logic          inject_a;

  logic [W-1:0]  a_tdata;
  logic          a_tvalid;
  logic [31:0]   a_wc;
  logic          a_busy;
  logic          a_done;
  logic [W-1:0]  b_tdata;
  logic          b_tvalid;
  logic [31:0]   b_wc;
  logic          b_busy;
  logic          b_done;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // History of generated bits, oldest first; always the last 31 bits.
  bit hist[$];

  always #5 clk = ~clk;

  prbs_stream_gen #(.TDATA_WIDTH(W)) u_a (
    .clk           (clk),
    .aresetn       (aresetn),
    .M_AXIS_TDATA  (a_tdata),
    .M_AXIS_TVALID (a_tvalid),
    .M_AXIS_TREADY (tready),
    .enable        (enable),
    .load_seed     (load_seed),
    .seed          (seed),
    .burst_len     (burst_len),
    .inject_err    (inject_a),
    .word_count    (a_wc),
    .busy          (a_busy),
    .done          (a_done)
  );

  // Reference twin with no error injection.
  prbs_stream_gen #(.TDATA_WIDTH(W)) u_b (
    .clk           (clk),
    .aresetn       (aresetn),
    .M_AXIS_TDATA  (b_tdata),
    .M_AXIS_TVALID (b_tvalid),
    .M_AXIS_TREADY (tready),
    .enable        (enable),
    .load_seed     (load_seed),
    .seed          (seed),
    .burst_len     (burst_len),
    .inject_err    (1'b0),
    .word_count    (b_wc),
    .busy          (b_busy),
    .done          (b_done)
  );

  function automatic void model_seed(input logic [30:0] s);
    logic [30:0] v;
    v = (s == 31'd0) ? 31'h7FFFFFFF : s;
    hist.delete();
    for (int k = 30; k >= 0; k--) hist.push_back(v[k]);
  endfunction

  // Sequence rule: new bit = bit 31 steps ago XOR bit 28 steps ago.
  function automatic logic [31:0] model_word();
    logic [31:0] w;
    bit nb;
    w = '0;
    for (int i = 0; i < W; i++) begin
      nb = hist[hist.size()-31] ^ hist[hist.size()-28];
      hist.push_back(nb);
      void'(hist.pop_front());
      w = {w[30:0], nb};
    end
    return w;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] w1;
    logic [31:0] first_ones;
    int          cnt;
    int          hcount;
    int          errs;
    int          blen;
    bit          hs;

    aresetn   = 1'b0;
    tready    = 1'b0;
    enable    = 1'b0;
    load_seed = 1'b0;
    inject_a  = 1'b0;
    seed      = 31'd0;
    burst_len = 32'd0;
    tick();
    tick();
    chk1 ("rst_tvalid", a_tvalid, 1'b0);
    chk32("rst_tdata",  a_tdata,  32'd0);
    chk32("rst_wc",     a_wc,     32'd0);
    chk1 ("rst_busy",   a_busy,   1'b0);
    chk1 ("rst_done",   a_done,   1'b0);
    aresetn = 1'b1;

    // Seed 1, continuous run, back-to-back.
    seed = 31'h1;
    load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    model_seed(31'h1);
    chk1("idle_tvalid", a_tvalid, 1'b0);
    enable = 1'b1;
    tready = 1'b1;
    burst_len = 32'd0;
    tick();
    exp_w = model_word();
    chk32("first_word_const", a_tdata, 32'h00000012);
    chk32("first_word_model", a_tdata, exp_w);
    chk1 ("first_tvalid", a_tvalid, 1'b1);
    chk1 ("first_busy",   a_busy,   1'b1);
    chk32("first_wc",     a_wc,     32'd0);
    for (int i = 1; i <= 12; i++) begin
      // A seed load mid-run must be ignored.
      if (i == 5) begin
        seed = 31'h5;
        load_seed = 1'b1;
      end else begin
        load_seed = 1'b0;
      end
      tick();
      exp_w = model_word();
      chk32("b2b_word",  a_tdata, exp_w);
      chk32("b2b_count", a_wc,    32'(i));
    end
    load_seed = 1'b0;
    cnt = 12;

    // Random backpressure.
    for (int i = 0; i < 40; i++) begin
      tready = 1'($urandom_range(0, 1));
      hs = a_tvalid && tready;
      tick();
      if (hs) begin
        exp_w = model_word();
        cnt++;
      end
      chk32("rnd_word",   a_tdata,  exp_w);
      chk32("rnd_count",  a_wc,     32'(cnt));
      chk1 ("rnd_tvalid", a_tvalid, 1'b1);
    end

    // Five-cycle stall.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk32("stall_word",   a_tdata,  exp_w);
      chk1 ("stall_tvalid", a_tvalid, 1'b1);
      chk32("stall_count",  a_wc,     32'(cnt));
    end

    // Enable dropped while stalled: word must still complete.
    enable = 1'b0;
    tick();
    chk1 ("drop_hold_tvalid", a_tvalid, 1'b1);
    chk32("drop_hold_word",   a_tdata,  exp_w);
    tick();
    chk1 ("drop_hold2_tvalid", a_tvalid, 1'b1);
    tready = 1'b1;
    tick();
    chk1 ("drop_end_tvalid", a_tvalid, 1'b0);
    chk1 ("drop_end_busy",   a_busy,   1'b0);
    chk32("drop_end_wc",     a_wc,     32'(cnt + 1));

    // Fixed burst of 3; burst_len changed after start must not matter.
    burst_len = 32'd3;
    enable = 1'b1;
    tick();
    exp_w = model_word();
    chk32("burst_w0", a_tdata, exp_w);
    chk32("burst_c0", a_wc,    32'd0);
    burst_len = 32'd100;
    tick();
    exp_w = model_word();
    chk32("burst_w1", a_tdata, exp_w);
    chk32("burst_c1", a_wc,    32'd1);
    tick();
    exp_w = model_word();
    chk32("burst_w2", a_tdata, exp_w);
    chk32("burst_c2", a_wc,    32'd2);
    tick();
    chk1 ("burst_end_tvalid", a_tvalid, 1'b0);
    chk1 ("burst_end_done",   a_done,   1'b1);
    chk1 ("burst_end_busy",   a_busy,   1'b0);
    chk32("burst_end_wc",     a_wc,     32'd3);
    tick();
    chk1("burst_done_hold", a_done, 1'b1);
    enable = 1'b0;
    tick();
    chk1("burst_idle_done", a_done, 1'b0);
    chk1("burst_idle_busy", a_busy, 1'b0);

    // Random-length bursts under random backpressure.
    for (int r = 0; r < 3; r++) begin
      blen = $urandom_range(2, 6);
      burst_len = 32'(blen);
      enable = 1'b1;
      tready = 1'b0;
      tick();
      exp_w = model_word();
      chk32("rburst_first", a_tdata, exp_w);
      hcount = 0;
      for (int c = 0; c < 200 && !a_done; c++) begin
        tready = 1'($urandom_range(0, 1));
        hs = a_tvalid && tready;
        tick();
        if (hs) begin
          hcount++;
          if (hcount < blen) begin
            exp_w = model_word();
            chk32("rburst_word", a_tdata, exp_w);
          end
        end
      end
      chk1 ("rburst_done",   a_done,   1'b1);
      chk32("rburst_hs",     32'(hcount), 32'(blen));
      chk32("rburst_wc",     a_wc,     32'(blen));
      chk1 ("rburst_tvalid", a_tvalid, 1'b0);
      enable = 1'b0;
      tready = 1'b1;
      tick();
    end

    // Error injection against the clean twin.
    seed = 31'h1234567;
    load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    model_seed(31'h1234567);
    enable = 1'b1;
    burst_len = 32'd0;
    tready = 1'b0;
    tick();
    w1 = model_word();
    chk32("inj_w1_a", a_tdata, w1);
    chk32("inj_w1_b", b_tdata, w1);
    errs = 0;
    inject_a = 1'b1;
    tick();
    inject_a = 1'b0;
    chk32("inj_w1_stalled", a_tdata, w1);
    inject_a = 1'b1;
    tick();
    inject_a = 1'b0;
    tick();
    chk32("inj_w1_still", a_tdata, w1);
    tready = 1'b1;
    for (int k = 2; k <= 7; k++) begin
      inject_a = (k == 5);
      tick();
      exp_w = model_word();
      if (k == 2 || k == 5) begin
        chk32("inj_word_flipped", a_tdata, exp_w ^ 32'd1);
        chk32("inj_diff_bit0",    a_tdata ^ b_tdata, 32'd1);
      end else begin
        chk32("inj_word_clean", a_tdata, exp_w);
      end
      chk32("inj_twin_word", b_tdata, exp_w);
      if (a_tdata !== b_tdata) errs++;
      if (k == 4) chk32("inj_err_count_1", 32'(errs), 32'd1);
    end
    inject_a = 1'b0;
    chk32("inj_err_count_2", 32'(errs), 32'd2);
    enable = 1'b0;
    tick();
    chk1("inj_idle", a_busy, 1'b0);

    // Zero seed with enable in the same cycle.
    seed = 31'd0;
    load_seed = 1'b1;
    enable = 1'b1;
    tick();
    load_seed = 1'b0;
    model_seed(31'h7FFFFFFF);
    exp_w = model_word();
    first_ones = exp_w;
    chk32("seed0_first", a_tdata, exp_w);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = model_word();
      chk32("seed0_word", a_tdata, exp_w);
    end

    // Reset mid-run, then restart with enable still high.
    aresetn = 1'b0;
    tick();
    chk1 ("mrst_tvalid", a_tvalid, 1'b0);
    chk32("mrst_wc",     a_wc,     32'd0);
    chk1 ("mrst_busy",   a_busy,   1'b0);
    chk32("mrst_tdata",  a_tdata,  32'd0);
    aresetn = 1'b1;
    tick();
    model_seed(31'h7FFFFFFF);
    exp_w = model_word();
    chk32("mrst_restart_model", a_tdata, exp_w);
    chk32("mrst_restart_ones",  a_tdata, first_ones);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_w = model_word();
      chk32("mrst_word", a_tdata, exp_w);
    end
    enable = 1'b0;
    tick();
    tick();
    chk1("final_idle", a_busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
